// File: rtl/ext_pipe_if.sv
// rtl/ext_pipe_if.sv - request/result handshake bundle for ext_pipe
interface ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int OFF_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       mode;
    logic [IN_W-1:0]  imm;
    logic [OUT_W-1:0] data;
    logic [OFF_W-1:0] off;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, mode, imm, data, off, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, mode, imm, data, off, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - immediate/load-lane extender feeding a 2-entry result FIFO
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int OFF_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    ext_pipe_if.slave   bus
);
    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W:0]   mem_q [2];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [OUT_W-1:0] res;
    logic             err;

    // Halfword base drops off[0]; a misaligned halfword is flagged, never read across lanes.
    assign byte_v = bus.data[{bus.off, 3'b000} +: 8];
    assign half_v = bus.data[{bus.off[OFF_W-1:1], 4'b0000} +: 16];

    always_comb begin
        res = '0;
        err = 1'b0;
        case (bus.mode)
            3'd0: res = {{EXT_W{1'b0}}, bus.imm};
            3'd1: res = {{EXT_W{bus.imm[IN_W-1]}}, bus.imm};
            3'd2: res = {bus.imm, {EXT_W{1'b0}}};
            3'd3: res = {{(OUT_W-8){byte_v[7]}}, byte_v};
            3'd4: res = {{(OUT_W-8){1'b0}}, byte_v};
            3'd5, 3'd6: begin
                if (bus.off[0]) begin
                    err = 1'b1;
                end else if (bus.mode == 3'd5) begin
                    res = {{(OUT_W-16){half_v[15]}}, half_v};
                end else begin
                    res = {{(OUT_W-16){1'b0}}, half_v};
                end
            end
            default: err = 1'b1;
        endcase
    end

    assign bus.in_ready  = (count_q < 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = mem_q[rptr_q][OUT_W-1:0];
    assign bus.out_err   = mem_q[rptr_q][OUT_W];

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) wptr_d = ~wptr_q;
            if (pop)  rptr_d = ~rptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push && !flush) mem_q[wptr_q] <= {err, res};
        end
    end
endmodule

// File: doc/ext_pipe.md
EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width.
REQ-002 Parameter OUT_W, default 32, result width; OUT_W SHALL be a multiple of 16 and greater than IN_W.
REQ-003 Parameter OFF_W, default 2, byte-offset width, equal to log2(OUT_W/8).
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous buffer clear.
REQ-007 in_valid  in  1  request present.
REQ-008 in_ready  out  1  block can accept a request this cycle.
REQ-009 mode  in  3  operation select (see REQ-015).
REQ-010 imm  in  IN_W  immediate operand for modes 0-2.
REQ-011 data  in  OUT_W  load word for modes 3-6.
REQ-012 off  in  OFF_W  byte offset into data, little-endian lanes.
REQ-013 out_valid, out_ready  out/in  1 each  result handshake.
REQ-014 out_data  out  OUT_W result; out_err  out  1  request was illegal or misaligned.

Function
REQ-015 Modes: 0 ZERO = zero-extend imm; 1 SIGN = sign-extend imm from bit IN_W-1; 2 UPPER = imm shifted left by OUT_W-IN_W, low bits zero; 3 LB = data byte at lane off, sign-extended; 4 LBU = same byte, zero-extended; 5 LH = halfword at lanes off and off+1, sign-extended; 6 LHU = same halfword, zero-extended.
REQ-016 Mode 7 is illegal: the result SHALL be all zeros and err SHALL be 1.
REQ-017 LH/LHU with off[0]=1 SHALL give result 0 with err=1; every other legal request gives err=0.
REQ-018 Storage is a 2-entry FIFO of {result, err}; the result is computed combinationally at enqueue and stored.
REQ-019 A transfer (push) SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-020 in_ready SHALL equal (count < 2) and SHALL depend only on registered state, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (count != 0); out_data/out_err SHALL show the head entry and hold stable while out_valid=1 and out_ready=0.
REQ-022 Latency is one cycle: a request pushed at edge N SHALL be visible at the output after edge N when the FIFO was empty.
REQ-023 Push and pop in the same cycle with count=1 SHALL leave count=1, with the head replaced by the new entry.
REQ-024 At count=2, in_ready=0 even when a pop occurs that cycle; in_ready rises the following cycle.
REQ-025 At count=0 there is no bypass: out_valid stays 0 during the push cycle.
REQ-026 Order is strict FIFO; entries are never dropped or duplicated.
REQ-027 flush=1 SHALL set count to 0 at the next edge and discard any simultaneous push and pop; out_valid=0 and in_ready=1 on the following cycle.
REQ-028 Read and write pointers are 1 bit each and wrap modulo 2.

Reset
REQ-029 reset=1 SHALL set count=0, both pointers=0, and every storage entry to zero at the next edge.
REQ-030 After reset, outputs SHALL read: out_valid=0, out_data=0, out_err=0, in_ready=1.
REQ-031 reset has priority over flush, push and pop; reset mid-stream discards all buffered entries.

Verification
REQ-032 SIGN, imm=16'h8001, out_ready=1 -> one cycle later out_valid=1, out_data=32'hFFFF8001, out_err=0; ZERO with the same imm -> 32'h00008001.
REQ-033 UPPER, imm=16'h1234 -> 32'h12340000; LB, data=32'h80FF7F01, off=3 -> 32'hFFFFFF80; LBU with off=1 -> 32'h0000007F.
REQ-034 LH, data=32'h8000_1234, off=2 -> 32'hFFFF8000; LH with off=1 -> out_data=0, out_err=1; mode=7 -> out_data=0, out_err=1.
REQ-035 Backpressure: with out_ready=0, push A then B -> in_ready=0 after the second push and C is not accepted; raise out_ready -> pops A then B, and in_ready returns to 1 one cycle after the first pop.
REQ-036 Streaming: in_valid=1 and out_ready=1 continuously for 8 requests -> one result per cycle after the first, in order, count never exceeds 1.
REQ-037 Reset and flush: with count=2, assert flush (or reset) together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the simultaneous request is not seen at the output.
